alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Uses the same 4-bit command encoding and flag set.
- Adds a start/busy/done handshake, registered results and flags, iterative shifts by arbitrary amounts, subtract, and an iterative shift-add multiply.
- Sits between the register file read ports and the write-back/branch logic of the multi-cycle core.

Parameters:
- W, 8, datapath width in bits (≥2).
- CNT_W, $clog2(W+1), width of the internal step counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted when start && !busy.
- alu_cmd  in  4  operation code, sampled on accept.
- inA  in  W  operand A, sampled on accept.
- inB  in  W  operand B / shift amount, sampled on accept.
- sc_i  in  1  shift/carry in, sampled on accept.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: rslt/flags just updated.
- rslt  out  W  registered result.
- sc_o  out  1  registered shift/carry out.
- pari  out  1  registered ^rslt.
- zero  out  1  registered (rslt==0).
- equal  out  1  registered (A==B) of last completed op.

Behaviour:
- Reset: one clock; asynchronous, active-high reset. While reset is high: FSM=IDLE; busy, done, rslt, sc_o, pari, zero, equal all 0. Reset mid-operation aborts the operation with no completion pulse.
- FSM states:
  - IDLE.
  - SHIFT.
  - MUL.
- Accept at edge k: A, B, sc_i, cmd are latched. N = step count:
  - shifts: N = min(inB, W).
  - mul: N = W.
  - all other ops: N = 0.
- N=0: result and flags written at edge k; done=1 during cycle k+1; busy stays 0.
- N>0: busy=1 after edge k. One step per edge. Result and flags are written at edge k+N, where busy→0 and done→1 together.
- done is high for exactly one cycle. start while busy is ignored (no latch, no effect). start with done high and busy low is accepted normally (back-to-back).
- rslt, sc_o, pari, zero, equal hold between completions.
- pari and zero are recomputed only when rslt is written. equal is recomputed on every completion except nop/reserved.
- Commands (arithmetic modulo 2^W):
  - 0000 add: rslt=A+B+sc_i; sc_o=carry out.
  - 0001 shl: N steps, each step shifts left 1 and fills with latched sc_i. sc_o=last bit shifted out (0 if N=0). Amount ≥W gives all-fill result.
  - 0010 shr: same as shl, logical right with sc_i fill.
  - 0011 mov: rslt=A; sc_o=0.
  - 0100 or, 0101 xor, 0110 and: bitwise; sc_o=0.
  - 0111 addi: rslt=A+B; carry-in ignored; sc_o=carry out.
  - 1000 bne, 1001 beq, 1101 cmp: only equal=(A==B) is updated. rslt, sc_o, pari, zero hold.
  - 1010 movi: rslt=A; sc_o=0.
  - 1011 sub: rslt=A−B; sc_o=borrow (A<B unsigned).
  - 1100 mul: unsigned shift-add over W steps into a 2W-bit accumulator. rslt=low W bits; sc_o=|high W bits (overflow).
  - 1110 reserved, 1111 nop: done pulses; all outputs hold.
- Step counter decrements per step; SHIFT/MUL return to IDLE when it reaches 0.
- Latched operands are stable during an operation; input changes while busy have no effect.

Test Plan:
- Reset, then add A=1, B=2, sc_i=0 → busy stays 0; done one cycle after accept; rslt=3, sc_o=0, zero=0, pari=0. Repeat with A=255, B=1 → rslt=0, sc_o=1, zero=1.
- shl A=0x02, B=3, sc_i=0 → busy for 3 cycles; rslt=0x10, sc_o=0, done coincident with busy falling. shr A=0x81, B=12, sc_i=1 (W=8) → 8 cycles; rslt=0xFF, sc_o=1.
- mul A=13, B=11 → done after 8 steps; rslt=143, sc_o=0. mul A=20, B=20 → rslt=144, sc_o=1. Assert start with A=0 while busy → ignored; rslt unchanged by it.
- sub A=5, B=7 → rslt=254, sc_o=1, pari=1. Then cmp A=B=1 → equal=1; rslt, pari, zero unchanged. Then bne A=1, B=2 → equal=0. Then nop → done pulse, all outputs hold.
- Back-to-back: add accepted in the cycle its predecessor's done is high → second done exactly one cycle later. Reset asserted mid-mul → all outputs 0 immediately; no done pulse; next add completes normally.
- Re-run the add/shift/mul scenarios at W=16: 0xFFFF+1 → rslt 0, sc_o=1; shl by 20 → 16 cycles, all-fill result; mul 300×300 → rslt=0x5F90, sc_o=1.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: start/busy/done handshake, registered result and flags,
// iterative shifts by arbitrary amounts and an iterative shift-add multiply.
module alu_mc #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         pari,
  output logic         zero,
  output logic         equal
);

  localparam logic [3:0] CMD_ADD  = 4'h0;
  localparam logic [3:0] CMD_SHL  = 4'h1;
  localparam logic [3:0] CMD_SHR  = 4'h2;
  localparam logic [3:0] CMD_MOV  = 4'h3;
  localparam logic [3:0] CMD_OR   = 4'h4;
  localparam logic [3:0] CMD_XOR  = 4'h5;
  localparam logic [3:0] CMD_AND  = 4'h6;
  localparam logic [3:0] CMD_ADDI = 4'h7;
  localparam logic [3:0] CMD_BNE  = 4'h8;
  localparam logic [3:0] CMD_BEQ  = 4'h9;
  localparam logic [3:0] CMD_MOVI = 4'hA;
  localparam logic [3:0] CMD_SUB  = 4'hB;
  localparam logic [3:0] CMD_MUL  = 4'hC;
  localparam logic [3:0] CMD_CMP  = 4'hD;

  // W expressed in operand and counter widths (W < 2**CNT_W <= 2**W for W >= 2)
  localparam logic [W-1:0]     W_OP  = W'(W);
  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     sh;
  logic             fill;
  logic             dir_left;
  logic             eq_lat;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   acc;

  logic [W:0]       add_full;
  logic [W:0]       addi_full;
  logic [W:0]       sub_full;
  logic [CNT_W-1:0] shift_n;
  logic [W-1:0]     sh_step;
  logic             sh_bit;
  logic [2*W-1:0]   acc_step;
  logic             fin_any;
  logic             fin_wr;
  logic             fin_eq;
  logic [W-1:0]     fin_val;
  logic             fin_c;
  logic             fin_eqv;

  // Next-step datapath values and the completion decision for this cycle
  always_comb begin
    add_full  = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
    addi_full = {1'b0, inA} + {1'b0, inB};
    sub_full  = {1'b0, inA} - {1'b0, inB};
    shift_n   = (inB >= W_OP) ? W_CNT : CNT_W'(inB);
    sh_step   = dir_left ? {sh[W-2:0], fill} : {fill, sh[W-1:1]};
    sh_bit    = dir_left ? sh[W-1] : sh[0];
    acc_step  = mplier[0] ? acc + mcand : acc;
    fin_any   = 1'b0;
    fin_wr    = 1'b0;
    fin_eq    = 1'b0;
    fin_val   = '0;
    fin_c     = 1'b0;
    fin_eqv   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          fin_eqv = (inA == inB);
          case (alu_cmd)
            CMD_ADD: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = add_full[W-1:0];
              fin_c   = add_full[W];
            end
            CMD_SHL, CMD_SHR: begin
              // zero-length shift completes immediately with A unchanged
              if (shift_n == '0) begin
                {fin_any, fin_wr, fin_eq} = 3'b111;
                fin_val = inA;
              end
            end
            CMD_MOV, CMD_MOVI: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = inA;
            end
            CMD_OR: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = inA | inB;
            end
            CMD_XOR: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = inA ^ inB;
            end
            CMD_AND: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = inA & inB;
            end
            CMD_ADDI: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = addi_full[W-1:0];
              fin_c   = addi_full[W];
            end
            CMD_SUB: begin
              {fin_any, fin_wr, fin_eq} = 3'b111;
              fin_val = sub_full[W-1:0];
              fin_c   = sub_full[W];
            end
            CMD_BNE, CMD_BEQ, CMD_CMP: begin
              fin_any = 1'b1;
              fin_eq  = 1'b1;
            end
            CMD_MUL: ;
            default: fin_any = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        if (cnt == ONE) begin
          {fin_any, fin_wr, fin_eq} = 3'b111;
          fin_val = sh_step;
          fin_c   = sh_bit;
          fin_eqv = eq_lat;
        end
      end
      MUL: begin
        if (cnt == ONE) begin
          {fin_any, fin_wr, fin_eq} = 3'b111;
          fin_val = acc_step[W-1:0];
          fin_c   = |acc_step[2*W-1:W];
          fin_eqv = eq_lat;
        end
      end
      default: ;
    endcase
  end

  // Control FSM, operand latches, iteration registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      fill     <= 1'b0;
      dir_left <= 1'b0;
      eq_lat   <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rslt     <= '0;
      sc_o     <= 1'b0;
      pari     <= 1'b0;
      zero     <= 1'b0;
      equal    <= 1'b0;
    end else begin
      done <= fin_any;
      if (fin_wr) begin
        rslt <= fin_val;
        sc_o <= fin_c;
        pari <= ^fin_val;
        zero <= (fin_val == '0);
      end
      if (fin_eq) equal <= fin_eqv;
      case (state)
        IDLE: begin
          if (start) begin
            eq_lat   <= (inA == inB);
            fill     <= sc_i;
            dir_left <= (alu_cmd == CMD_SHL);
            sh       <= inA;
            mcand    <= {{W{1'b0}}, inA};
            mplier   <= inB;
            acc      <= '0;
            if ((alu_cmd == CMD_SHL || alu_cmd == CMD_SHR) && shift_n != '0) begin
              state <= SHIFT;
              cnt   <= shift_n;
              busy  <= 1'b1;
            end else if (alu_cmd == CMD_MUL) begin
              state <= MUL;
              cnt   <= W_CNT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          sh  <= sh_step;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - ONE;
          if (cnt == ONE) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc at W=8 and W=16, with a
// closed-form arithmetic reference model and handshake timing checks.
module tb_alu_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st8, sc8, busy8, done8, sco8, pari8, zero8, eq8;
  logic [3:0]  cmd8;
  logic [7:0]  a8, b8, rslt8;
  logic        st16, sc16, busy16, done16, sco16, pari16, zero16, eq16;
  logic [3:0]  cmd16;
  logic [15:0] a16, b16, rslt16;

  alu_mc #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .alu_cmd(cmd8), .inA(a8), .inB(b8),
    .sc_i(sc8), .busy(busy8), .done(done8), .rslt(rslt8), .sc_o(sco8),
    .pari(pari8), .zero(zero8), .equal(eq8)
  );

  alu_mc #(.W(16)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .alu_cmd(cmd16), .inA(a16), .inB(b16),
    .sc_i(sc16), .busy(busy16), .done(done16), .rslt(rslt16), .sc_o(sco16),
    .pari(pari16), .zero(zero16), .equal(eq16)
  );

  int checks = 0;
  int errors = 0;

  // outputs of whichever instance is currently being exercised
  bit          sel16;
  logic        o_busy, o_done, o_sc, o_pari, o_zero, o_eq;
  logic [15:0] o_rslt;
  always_comb begin
    o_busy = sel16 ? busy16 : busy8;
    o_done = sel16 ? done16 : done8;
    o_rslt = sel16 ? rslt16 : {8'h00, rslt8};
    o_sc   = sel16 ? sco16  : sco8;
    o_pari = sel16 ? pari16 : pari8;
    o_zero = sel16 ? zero16 : zero8;
    o_eq   = sel16 ? eq16   : eq8;
  end

  // reference state per width (index 0: W=8, 1: W=16)
  logic [63:0] m_rslt [2];
  bit          m_sc   [2];
  bit          m_pari [2];
  bit          m_zero [2];
  bit          m_eq   [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rslt[i] = '0; m_sc[i] = 0; m_pari[i] = 0; m_zero[i] = 0; m_eq[i] = 0;
    end
  endtask

  // Reference: result of one command from plain arithmetic; returns step count
  task automatic model(input int w, input logic [3:0] cmd, input logic [63:0] a,
                       input logic [63:0] b, input bit sc, output int n);
    logic [63:0] mask, r, s, full;
    bit c, ur, ue;
    int idx;
    mask = (64'd1 << w) - 1;
    idx  = (w == 16) ? 1 : 0;
    r = '0; c = 0; ur = 0; ue = 0; n = 0;
    case (cmd)
      4'h0: begin s = a + b + 64'(sc); r = s & mask; c = s[w]; ur = 1; ue = 1; end
      4'h1, 4'h2: begin
        n = (b >= 64'(w)) ? w : int'(b);
        ur = 1; ue = 1;
        if (n == 0) begin
          r = a;
        end else if (cmd == 4'h1) begin
          full = (a << n) | (sc ? ((64'd1 << n) - 1) : 64'd0);
          r = full & mask;
          c = full[w];
        end else begin
          r = ((a >> n) | (sc ? (mask & ~(mask >> n)) : 64'd0)) & mask;
          full = a >> (n - 1);
          c = full[0];
        end
      end
      4'h3, 4'hA: begin r = a; ur = 1; ue = 1; end
      4'h4: begin r = a | b; ur = 1; ue = 1; end
      4'h5: begin r = a ^ b; ur = 1; ue = 1; end
      4'h6: begin r = a & b; ur = 1; ue = 1; end
      4'h7: begin s = a + b; r = s & mask; c = s[w]; ur = 1; ue = 1; end
      4'h8, 4'h9, 4'hD: ue = 1;
      4'hB: begin r = (a - b) & mask; c = (a < b); ur = 1; ue = 1; end
      4'hC: begin
        n = w;
        s = a * b;
        r = s & mask;
        c = ((s >> w) != 0);
        ur = 1; ue = 1;
      end
      default: ;
    endcase
    if (ur) begin
      m_rslt[idx] = r;
      m_sc[idx]   = c;
      m_pari[idx] = ($countones(r) % 2) == 1;
      m_zero[idx] = (r == 0);
    end
    if (ue) m_eq[idx] = (a == b);
  endtask

  task automatic drive(input int w, input bit st, input logic [3:0] cmd,
                       input logic [15:0] a, input logic [15:0] b, input bit sc);
    if (w == 16) begin
      st16 = st; cmd16 = cmd; a16 = a; b16 = b; sc16 = sc; st8 = 1'b0;
    end else begin
      st8 = st; cmd8 = cmd; a8 = a[7:0]; b8 = b[7:0]; sc8 = sc; st16 = 1'b0;
    end
  endtask

  // One transaction: accept, scramble inputs while busy, optionally poke a
  // start mid-operation, then check latency, handshake and registered outputs.
  task automatic run_op(input int w, input logic [3:0] cmd, input logic [15:0] a,
                        input logic [15:0] b, input bit sc, input bit poke, input bit gap);
    int n, cyc, idx;
    logic [15:0] mask;
    mask  = (w == 16) ? 16'hFFFF : 16'h00FF;
    idx   = (w == 16) ? 1 : 0;
    sel16 = (w == 16);
    a = a & mask;
    b = b & mask;
    model(w, cmd, 64'(a), 64'(b), sc, n);
    @(negedge clk);
    drive(w, 1'b1, cmd, a, b, sc);
    @(posedge clk); #1;
    drive(w, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    chk("accept_busy", o_busy, 64'(n > 0));
    chk("accept_done", o_done, 64'(n == 0));
    cyc = 0;
    while (!o_done && cyc < 40) begin
      if (poke && cyc == 1)
        drive(w, 1'b1, 4'h0, 16'h0000, 16'($urandom), 1'b0);
      else
        drive(w, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      if (cyc > 0) chk("busy_hold", o_busy, 64'd1);
      @(posedge clk); #1;
      cyc++;
    end
    drive(w, 1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0);
    chk("latency", cyc, n);
    chk("busy_at_done", o_busy, 64'd0);
    chk("rslt", o_rslt, m_rslt[idx]);
    chk("sc_o", o_sc, 64'(m_sc[idx]));
    chk("pari", o_pari, 64'(m_pari[idx]));
    chk("zero", o_zero, 64'(m_zero[idx]));
    chk("equal", o_eq, 64'(m_eq[idx]));
    $display("op w=%0d cmd=%h a=%h b=%h sc=%0d steps=%0d -> rslt=%h sc_o=%0d pari=%0d zero=%0d equal=%0d",
             w, cmd, a, b, sc, cyc, o_rslt, o_sc, o_pari, o_zero, o_eq);
    if (gap) begin
      @(posedge clk); #1;
      chk("done_pulse", o_done, 64'd0);
    end
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    sel16 = 1'b0;
    drive(8, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_rslt", rslt8, 0);
    chk("rst_flags", {sco8, pari8, zero8, eq8}, 0);
    chk("rst_rslt16", rslt16, 0);
    @(negedge clk);
    reset = 1'b0;

    // directed scenarios at W=8
    run_op(8, 4'h0, 16'd1, 16'd2, 1'b0, 0, 1);
    chk("tp_add", o_rslt, 3);
    run_op(8, 4'h0, 16'd255, 16'd1, 1'b0, 0, 1);
    chk("tp_add_wrap", {o_rslt, o_sc, o_zero}, {16'd0, 1'b1, 1'b1});
    run_op(8, 4'h1, 16'h02, 16'd3, 1'b0, 0, 1);
    chk("tp_shl", o_rslt, 16'h10);
    run_op(8, 4'h2, 16'h81, 16'd12, 1'b1, 0, 1);
    chk("tp_shr", {o_rslt, o_sc}, {16'hFF, 1'b1});
    run_op(8, 4'hC, 16'd13, 16'd11, 1'b0, 1, 1);
    chk("tp_mul", {o_rslt, o_sc}, {16'd143, 1'b0});
    run_op(8, 4'hC, 16'd20, 16'd20, 1'b0, 0, 1);
    chk("tp_mul_ovf", {o_rslt, o_sc}, {16'd144, 1'b1});
    run_op(8, 4'hB, 16'd5, 16'd7, 1'b0, 0, 1);
    chk("tp_sub", {o_rslt, o_sc, o_pari}, {16'd254, 1'b1, 1'b1});
    run_op(8, 4'hD, 16'd1, 16'd1, 1'b0, 0, 1);
    chk("tp_cmp", {o_eq, o_rslt}, {1'b1, 16'd254});
    run_op(8, 4'h8, 16'd1, 16'd2, 1'b0, 0, 1);
    run_op(8, 4'hF, 16'd3, 16'd3, 1'b1, 0, 1);
    // back-to-back: second add accepted while first done is high
    run_op(8, 4'h0, 16'd10, 16'd20, 1'b1, 0, 0);
    run_op(8, 4'h0, 16'd7, 16'd7, 1'b0, 0, 1);

    // reset in the middle of a multiply
    @(negedge clk);
    drive(8, 1'b1, 4'hC, 16'd99, 16'd77, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 4'h0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_outs", {busy8, done8, rslt8, sco8, pari8, zero8, eq8}, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    chk("midrst_no_done", seen, 0);
    run_op(8, 4'h0, 16'd4, 16'd5, 1'b0, 0, 1);

    // W=16 scenarios
    run_op(16, 4'h0, 16'hFFFF, 16'd1, 1'b0, 0, 1);
    chk("tp16_add", {o_rslt, o_sc}, {16'd0, 1'b1});
    run_op(16, 4'h1, 16'h1235, 16'd20, 1'b1, 0, 1);
    chk("tp16_shl", o_rslt, 16'hFFFF);
    run_op(16, 4'hC, 16'd300, 16'd300, 1'b0, 0, 1);
    chk("tp16_mul", {o_rslt, o_sc}, {16'h5F90, 1'b1});

    // random mix of widths, commands and operands
    for (int i = 0; i < 300; i++) begin
      int w;
      logic [3:0] cmd;
      logic [15:0] a, b;
      w   = ($urandom_range(1, 0) == 1) ? 16 : 8;
      cmd = 4'($urandom_range(15, 0));
      a   = 16'($urandom);
      b   = 16'($urandom);
      if ((cmd == 4'h1 || cmd == 4'h2) && $urandom_range(1, 0) == 1)
        b = 16'($urandom_range(w + 3, 0));
      if ($urandom_range(4, 0) == 0) b = a;
      run_op(w, cmd, a, b, 1'($urandom), $urandom_range(7, 0) == 0, $urandom_range(1, 0) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
